// File: rtl/popcount11_unary_tx.sv
// Serialises a CW-bit count as an N_BITS-long unary (thermometer) frame, ones first.
// Optional self-check monitor: define POPCOUNT11_UNARY_TX_CHECK_EN.
module popcount11_unary_tx #(
    parameter int N_BITS   = 11,
    parameter int CW       = 4,
    parameter int IDLE_GAP = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] in_count,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_bit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          err_range,
    output logic          err_check
);

    localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP + 1) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t        state;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] idx;
    logic [CW-1:0] idx_nxt;
    logic [CW-1:0] cnt_in;
    logic [GW-1:0] gap_cnt;
    logic          accept;
    logic          out_hs;
    logic          last_hs;

    // A new count may be taken in the same cycle the previous frame's last bit leaves
    assign in_ready = !rst && ((state == IDLE) ||
                      ((IDLE_GAP == 0) && (state == SHIFT) && out_last && out_ready));

    always_comb begin
        accept  = in_valid & in_ready;
        out_hs  = out_valid & out_ready;
        last_hs = out_hs & out_last;
        idx_nxt = idx + CW'(1);
        cnt_in  = (in_count > CW'(N_BITS)) ? CW'(N_BITS) : in_count;
    end

    // Outputs are registered and precomputed from the index they will present next
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt_q     <= '0;
            idx       <= '0;
            gap_cnt   <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
            err_range <= 1'b0;
        end else begin
            err_range <= 1'b0;
            if (accept) begin
                state     <= SHIFT;
                cnt_q     <= cnt_in;
                idx       <= '0;
                out_valid <= 1'b1;
                out_bit   <= (cnt_in != '0);
                out_last  <= (N_BITS == 1);
                err_range <= (in_count > CW'(N_BITS));
            end else begin
                case (state)
                    SHIFT: begin
                        if (out_hs) begin
                            if (out_last) begin
                                out_valid <= 1'b0;
                                out_bit   <= 1'b0;
                                out_last  <= 1'b0;
                                idx       <= '0;
                                gap_cnt   <= '0;
                                state     <= (IDLE_GAP > 0) ? GAP : IDLE;
                            end else begin
                                idx      <= idx_nxt;
                                out_bit  <= (idx_nxt < cnt_q);
                                out_last <= (idx_nxt == CW'(N_BITS - 1));
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt == GW'(IDLE_GAP - 1)) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef POPCOUNT11_UNARY_TX_CHECK_EN
    logic [CW-1:0] sum_q;

    // Independent ones-counter: a frame whose emitted ones disagree with cnt_q flags a shift fault
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q     <= '0;
            err_check <= 1'b0;
        end else begin
            err_check <= 1'b0;
            if (last_hs) begin
                err_check <= ((sum_q + CW'(out_bit)) != cnt_q);
            end
            if (accept) begin
                sum_q <= '0;
            end else if (out_hs) begin
                sum_q <= sum_q + CW'(out_bit);
            end
        end
    end
`else
    assign err_check = 1'b0;
`endif

endmodule

// File: tb/tb_popcount11_unary_tx.sv
// Directed testbench for popcount11_unary_tx: reset, frame contents, back-to-back,
// range clamp, stalls and the optional self-check monitor.
module tb_popcount11_unary_tx;

    localparam int N_BITS = 11;
    localparam int CW     = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] in_count = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          out_bit;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          err_range;
    logic          err_check;

    int n_checks = 0;
    int n_pass   = 0;

    popcount11_unary_tx #(.N_BITS(N_BITS), .CW(CW), .IDLE_GAP(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_count  (in_count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .err_range (err_range),
        .err_check (err_check)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    // Offer one count; the accept edge happens at the next posedge
    task automatic applyStimulus(input int cnt);
        checkOutput("in_ready before accept", int'(in_ready), 1);
        in_count = 4'(cnt);
        in_valid = 1'b1;
        stepClk();
        in_valid = 1'b0;
        in_count = 4'(15);
    endtask

    // Collects one frame right after its accept edge; stall=1 applies the 1,0,0,1 ready pattern
    task automatic runFrame(input int cnt_exp, input bit stall, input string tag);
        int xfer = 0;
        int cyc  = 0;
        while (xfer < N_BITS && cyc < 200) begin
            out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            checkOutput({tag, " valid"}, int'(out_valid), 1);
            checkOutput({tag, " bit"}, int'(out_bit), int'(xfer < cnt_exp));
            checkOutput({tag, " last"}, int'(out_last), int'(xfer == N_BITS - 1));
            if (cyc > 0) checkOutput({tag, " err_range idle"}, int'(err_range), 0);
            if (out_ready && out_valid) xfer++;
            stepClk();
            cyc++;
        end
        out_ready = 1'b1;
        checkOutput({tag, " transfers"}, xfer, N_BITS);
        checkOutput({tag, " valid after"}, int'(out_valid), 0);
        checkOutput({tag, " err_check"}, int'(err_check), 0);
    endtask

    initial begin
        // Reset state
        #2;
        checkOutput("rst in_ready", int'(in_ready), 0);
        checkOutput("rst out_valid", int'(out_valid), 0);
        checkOutput("rst out_bit", int'(out_bit), 0);
        checkOutput("rst out_last", int'(out_last), 0);
        checkOutput("rst err_range", int'(err_range), 0);
        checkOutput("rst err_check", int'(err_check), 0);
        stepClk();
        stepClk();
        rst = 1'b0;
        #1;
        checkOutput("post-rst in_ready", int'(in_ready), 1);

        // Count 5: five ones then six zeros, valid one cycle after accept
        applyStimulus(5);
        checkOutput("c5 err_range", int'(err_range), 0);
        runFrame(5, 1'b0, "c5");

        // Reset after 5 bits of count 7 drops the frame
        applyStimulus(7);
        for (int i = 0; i < 5; i++) begin
            checkOutput("c7 bit", int'(out_bit), 1);
            stepClk();
        end
        rst = 1'b1;
        #1;
        checkOutput("midrst out_valid", int'(out_valid), 0);
        checkOutput("midrst out_bit", int'(out_bit), 0);
        checkOutput("midrst in_ready", int'(in_ready), 0);
        stepClk();
        rst = 1'b0;
        #1;
        checkOutput("midrst release in_ready", int'(in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("midrst no bits", int'(out_valid), 0);
            stepClk();
        end

        // Back-to-back 0 then 11: 22 valid cycles, no bubble
        applyStimulus(0);
        in_count = 4'd11;
        in_valid = 1'b1;
        for (int i = 0; i < 2 * N_BITS; i++) begin
            checkOutput("b2b valid", int'(out_valid), 1);
            checkOutput("b2b bit", int'(out_bit), int'(i >= N_BITS));
            checkOutput("b2b last", int'(out_last), int'(i == N_BITS - 1 || i == 2 * N_BITS - 1));
            checkOutput("b2b in_ready", int'(in_ready), int'(i == N_BITS - 1 || i == 2 * N_BITS - 1));
            stepClk();
            if (i == N_BITS - 1) in_valid = 1'b0;
        end
        checkOutput("b2b end valid", int'(out_valid), 0);

        // Out-of-range count clamps to all ones and pulses err_range once
        applyStimulus(14);
        checkOutput("c14 err_range", int'(err_range), 1);
        runFrame(11, 1'b0, "c14");

        // in_valid dropped while idle with no transfer changes nothing
        in_count = 4'd3;
        #1;
        stepClk();
        checkOutput("no-accept valid", int'(out_valid), 0);

        // Count 6 with ready toggling 1,0,0,1
        applyStimulus(6);
        runFrame(6, 1'b1, "c6stall");

`ifdef POPCOUNT11_UNARY_TX_CHECK_EN
        // Glitch idx while stalled; fewer ones than latched must raise err_check
        begin
            int cyc = 0;
            bit done = 1'b0;
            applyStimulus(5);
            stepClk();
            stepClk();
            out_ready = 1'b0;
            force dut.idx = 4'd6;
            stepClk();
            release dut.idx;
            out_ready = 1'b1;
            while (!done && cyc < 40) begin
                if (out_valid && out_last) done = 1'b1;
                stepClk();
                cyc++;
            end
            checkOutput("glitch frame ended", int'(done), 1);
            checkOutput("glitch err_check", int'(err_check), 1);
            stepClk();
        end
`endif

        // Random counts 0..11 with a correct shifter never raise err_check
        for (int k = 0; k < 1000; k++) begin
            int c;
            c = int'($urandom_range(0, 11));
            applyStimulus(c);
            runFrame(c, k[0], "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog so the bench always terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
